// File: rtl/intersection_sched.sv
// intersection_sched -- phase scheduler for a two-direction (A/B) signalised
// intersection. Walks both heads through green, yellow and all-red on a 1 s
// tick, extends green while the own direction keeps demanding (up to T_GMAX),
// and optionally inserts a pedestrian walk phase at the B->A clearance point.
//
// Optional feature: INTERSECTION_PED_EN builds the PED state, the pend_p latch
// and the walk lamp. Without it ped_req is ignored, walk is tied low and
// encoding 6 is treated as undefined.
//
// Ports:
//   clk      single clock
//   rst      synchronous, active-low reset
//   tick     one-cycle 1 s enable strobe; state changes only on tick edges
//   req_a    A-direction vehicle sensor (level or pulse)
//   req_b    B-direction vehicle sensor (level or pulse)
//   ped_req  pedestrian button (level or pulse)
//   a_rgy    A head lamps {r,g,y}, registered
//   b_rgy    B head lamps {r,g,y}, registered
//   walk     walk lamp, registered
//   phase    current state encoding, for debug
//
// Request handshake: requests have no ready/ack. Each request input is sampled
// every cycle into a sticky pend_* latch; the latch drops on the cycle the
// scheduler enters that demand's serving state, and that clear beats a
// simultaneous set.
module intersection_sched #(
  parameter int T_GMIN = 10,
  parameter int T_GMAX = 25,
  parameter int T_YEL  = 5,
  parameter int T_ARED = 1,
  parameter int T_WALK = 8,
  parameter int CW     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ped_req,
  output logic [2:0] a_rgy,
  output logic [2:0] b_rgy,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GRN   = 3'd0,
    A_YEL   = 3'd1,
    ARED_AB = 3'd2,
    B_GRN   = 3'd3,
    B_YEL   = 3'd4,
    ARED_BA = 3'd5,
    PED     = 3'd6
  } state_t;

  localparam logic [CW-1:0] GMIN_M1 = CW'(T_GMIN - 1);
  localparam logic [CW-1:0] GMAX_M1 = CW'(T_GMAX - 1);
  localparam logic [CW-1:0] YEL_M1  = CW'(T_YEL - 1);
  localparam logic [CW-1:0] ARED_M1 = CW'(T_ARED - 1);
  localparam logic [CW-1:0] WALK_M1 = CW'(T_WALK - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          pend_a;
  logic          pend_b;
  logic          is_green;

`ifdef INTERSECTION_PED_EN
  logic          pend_p;
  logic          walk_r;
`else
  logic          unused_ped;
  assign unused_ped = ped_req;
`endif

  // {a_rgy, b_rgy} for a given state; any unknown encoding shows all-red.
  function automatic logic [5:0] lamps(state_t s);
    case (s)
      A_GRN:   lamps = {3'b010, 3'b100};
      A_YEL:   lamps = {3'b001, 3'b100};
      B_GRN:   lamps = {3'b100, 3'b010};
      B_YEL:   lamps = {3'b100, 3'b001};
      default: lamps = {3'b100, 3'b100};
    endcase
  endfunction

  assign is_green = (state == A_GRN) || (state == B_GRN);
  assign phase    = state;

  // Green yields only when the other side is waiting, the minimum has been
  // served, and either the own sensor has gone quiet or the maximum is hit.
  always_comb begin
    state_nx = state;
    case (state)
      A_GRN:   if (tick && pend_b && (cnt >= GMIN_M1) && (!req_a || (cnt >= GMAX_M1)))
                 state_nx = A_YEL;
      A_YEL:   if (tick && (cnt == YEL_M1))  state_nx = ARED_AB;
      ARED_AB: if (tick && (cnt == ARED_M1)) state_nx = B_GRN;
      B_GRN:   if (tick && pend_a && (cnt >= GMIN_M1) && (!req_b || (cnt >= GMAX_M1)))
                 state_nx = B_YEL;
      B_YEL:   if (tick && (cnt == YEL_M1))  state_nx = ARED_BA;
`ifdef INTERSECTION_PED_EN
      ARED_BA: if (tick && (cnt == ARED_M1)) state_nx = pend_p ? PED : A_GRN;
      PED:     if (tick && (cnt == WALK_M1)) state_nx = A_GRN;
`else
      ARED_BA: if (tick && (cnt == ARED_M1)) state_nx = A_GRN;
`endif
      default: state_nx = ARED_BA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ARED_BA;
      cnt    <= '0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      a_rgy  <= 3'b100;
      b_rgy  <= 3'b100;
`ifdef INTERSECTION_PED_EN
      pend_p <= 1'b0;
      walk_r <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      {a_rgy, b_rgy} <= lamps(state_nx);

      // Counter restarts on every state change; in green it parks at
      // T_GMAX-1 so an unopposed green can hold forever without wrapping.
      if (state_nx != state)
        cnt <= '0;
      else if (tick && !(is_green && (cnt >= GMAX_M1)))
        cnt <= cnt + CW'(1);

      pend_a <= ((state_nx == A_GRN) && (state != A_GRN)) ? 1'b0 : (pend_a | req_a);
      pend_b <= ((state_nx == B_GRN) && (state != B_GRN)) ? 1'b0 : (pend_b | req_b);
`ifdef INTERSECTION_PED_EN
      pend_p <= ((state_nx == PED) && (state != PED)) ? 1'b0 : (pend_p | ped_req);
      walk_r <= (state_nx == PED);
`endif
    end
  end

`ifdef INTERSECTION_PED_EN
  assign walk = walk_r;
`else
  assign walk = 1'b0;
`endif

endmodule

// File: tb/tb_intersection_sched.sv
// tb_intersection_sched -- self-checking bench for intersection_sched.
// Directed scenarios followed by randomized traffic, all compared cycle by
// cycle against a phase-level reference model that tracks elapsed ticks per
// phase as an unbounded integer.
module tb_intersection_sched;

  localparam int T_GMIN = 10;
  localparam int T_GMAX = 25;
  localparam int T_YEL  = 5;
  localparam int T_ARED = 1;
  localparam int T_WALK = 8;
`ifdef INTERSECTION_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] a_rgy;
  logic [2:0] b_rgy;
  logic       walk;
  logic [2:0] phase;

  intersection_sched #(
    .T_GMIN(T_GMIN), .T_GMAX(T_GMAX), .T_YEL(T_YEL),
    .T_ARED(T_ARED), .T_WALK(T_WALK), .CW(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .req_a(req_a), .req_b(req_b), .ped_req(ped_req),
    .a_rgy(a_rgy), .b_rgy(b_rgy), .walk(walk), .phase(phase)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_phase = 5;
  int m_el = 0;
  bit m_pa = 0, m_pb = 0, m_pp = 0;

  // phase duration bookkeeping (cycles observed per completed phase)
  int cyc = 0;
  int prev_ph = 5;
  int run_len = 0;
  int len_of [8];
  int tick_period = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] exp_a(input int ph);
    case (ph)
      0: exp_a = 3'b010;
      1: exp_a = 3'b001;
      default: exp_a = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_b(input int ph);
    case (ph)
      3: exp_b = 3'b010;
      4: exp_b = 3'b001;
      default: exp_b = 3'b100;
    endcase
  endfunction

  // Phase-level model: each phase has a duration in ticks; greens end once
  // served long enough and the other side waits.
  task automatic model_step(input logic r, t, ra, rb, rp);
    int nxt;
    int el1;
    if (!r) begin
      m_phase = 5; m_el = 0; m_pa = 0; m_pb = 0; m_pp = 0;
      return;
    end
    nxt = m_phase;
    el1 = m_el + 1;
    if (t) begin
      case (m_phase)
        0: if (m_pb && el1 >= T_GMIN && (!ra || el1 >= T_GMAX)) nxt = 1;
        1: if (el1 == T_YEL) nxt = 2;
        2: if (el1 == T_ARED) nxt = 3;
        3: if (m_pa && el1 >= T_GMIN && (!rb || el1 >= T_GMAX)) nxt = 4;
        4: if (el1 == T_YEL) nxt = 5;
        5: if (el1 == T_ARED) nxt = (PED_EN && m_pp) ? 6 : 0;
        6: if (el1 == T_WALK) nxt = 0;
        default: nxt = 5;
      endcase
    end
    m_pa = (nxt == 0 && m_phase != 0) ? 1'b0 : (m_pa | ra);
    m_pb = (nxt == 3 && m_phase != 3) ? 1'b0 : (m_pb | rb);
    m_pp = PED_EN && ((nxt == 6 && m_phase != 6) ? 1'b0 : (m_pp | rp));
    m_el = (nxt != m_phase) ? 0 : (t ? el1 : m_el);
    m_phase = nxt;
  endtask

  // driver: apply one cycle of inputs, step the model, compare outputs
  task automatic run_cycle(input logic r, t, ra, rb, rp);
    rst = r; tick = t; req_a = ra; req_b = rb; ped_req = rp;
    @(posedge clk);
    #1;
    model_step(r, t, ra, rb, rp);
    cyc++;
    check("phase", 32'(phase), 32'(m_phase));
    check("a_rgy", 32'(a_rgy), 32'(exp_a(m_phase)));
    check("b_rgy", 32'(b_rgy), 32'(exp_b(m_phase)));
    check("walk", 32'(walk), 32'(m_phase == 6));
    check("one_head_red", 32'((a_rgy == 3'b100) || (b_rgy == 3'b100)), 32'd1);
    if (int'(phase) != prev_ph) begin
      check("change_on_tick", 32'(!r || t), 32'd1);
      len_of[prev_ph] = run_len;
      run_len = 1;
      prev_ph = int'(phase);
    end else begin
      run_len++;
    end
  endtask

  function automatic logic cur_tick();
    return (cyc % tick_period) == 0;
  endfunction

  task automatic run_until(input int target, input logic ra, rb, rp, input int limit);
    int n = 0;
    while (int'(phase) != target && n < limit) begin
      run_cycle(1'b1, cur_tick(), ra, rb, rp);
      n++;
    end
    if (int'(phase) != target) check("timeout_phase", 32'(phase), 32'(target));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) len_of[i] = 0;

    // Reset state
    repeat (3) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_phase", 32'(phase), 32'd5);
    check("rst_a", 32'(a_rgy), 32'h4);
    check("rst_b", 32'(b_rgy), 32'h4);

    // Release with no requests: one all-red cycle then green held
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("first_green", 32'(phase), 32'd0);
    repeat (100) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("green_held", 32'(phase), 32'd0);

    // Fresh green, req_b pulse at cycle 3: 10 / 5 / 1 then B_GRN
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_until(3, 1'b0, 1'b0, 1'b0, 100);
    check("agrn_min_len", 32'(len_of[0]), 32'd10);
    check("ayel_len", 32'(len_of[1]), 32'd5);
    check("ared_ab_len", 32'(len_of[2]), 32'd1);

    // Back to A, then hold req_a with a req_b pulse: green stretches to max
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_until(0, 1'b0, 1'b0, 1'b0, 100);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    run_until(1, 1'b1, 1'b0, 1'b0, 100);
    check("agrn_max_len", 32'(len_of[0]), 32'd25);

    // Pedestrian request during B_GRN with A pending
    run_until(3, 1'b0, 1'b0, 1'b0, 100);
    repeat (2) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    run_until(5, 1'b0, 1'b0, 1'b0, 100);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("after_ared_ba", 32'(phase), PED_EN ? 32'd6 : 32'd0);
    check("walk_after_ared", 32'(walk), PED_EN ? 32'd1 : 32'd0);
    run_until(0, 1'b0, 1'b0, 1'b0, 100);
    check("byel_len", 32'(len_of[4]), 32'd5);
    check("ared_ba_len", 32'(len_of[5]), 32'd1);
    check("ped_len", 32'(len_of[6]), PED_EN ? 32'd8 : 32'd0);

    // Reset during B_YEL with demand pending: all-red, pends cleared
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_until(3, 1'b0, 1'b0, 1'b0, 100);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_until(4, 1'b0, 1'b0, 1'b0, 100);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst_phase", 32'(phase), 32'd5);
    check("midrst_a", 32'(a_rgy), 32'h4);
    check("midrst_b", 32'(b_rgy), 32'h4);
    repeat (40) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pend_cleared_green_held", 32'(phase), 32'd0);

    // Slow tick: every 4th cycle, yellow lasts 20 cycles
    tick_period = 4;
    run_cycle(1'b1, cur_tick(), 1'b0, 1'b1, 1'b0);
    run_until(2, 1'b0, 1'b0, 1'b0, 400);
    check("slow_yel_len", 32'(len_of[1]), 32'd20);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      run_cycle(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
